// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational from fetch_pc; updates from execute land on the next rising edge.
module btb_predictor #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        predictedTaken,
    output logic [31:0] predicted_target,
    output logic [31:0] next_fetch_pc,
    input  logic        update_btb,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        flush_btb
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagW    = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrSt  = 2'b10,
        CtrWt  = 2'b11
    } ctr_e;

    logic [Entries-1:0] valid_q;
    logic [TagW-1:0]    tag_q    [Entries];
    logic [31:0]        target_q [Entries];
    ctr_e               state_q  [Entries];

    logic [INDEX_BITS-1:0] f_idx, e_idx;
    logic [TagW-1:0]       f_tag, e_tag;
    logic                  f_hit, e_hit;
    ctr_e                  e_state_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[31:INDEX_BITS+2];
    assign e_idx = ex_pc[INDEX_BITS+1:2];
    assign e_tag = ex_pc[31:INDEX_BITS+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    always_comb begin
        predictedTaken   = f_hit && state_q[f_idx][1];
        predicted_target = 32'd0;
        next_fetch_pc    = fetch_pc + 32'd4;
        if (predictedTaken) begin
            predicted_target = target_q[f_idx];
            next_fetch_pc    = target_q[f_idx];
        end
    end

    always_comb begin
        e_state_d = state_q[e_idx];
        if (ex_taken) begin
            unique case (state_q[e_idx])
                CtrSnt:  e_state_d = CtrWnt;
                CtrWnt:  e_state_d = CtrWt;
                CtrWt:   e_state_d = CtrSt;
                default: e_state_d = CtrSt;
            endcase
        end else begin
            unique case (state_q[e_idx])
                CtrSt:   e_state_d = CtrWt;
                CtrWt:   e_state_d = CtrWnt;
                CtrWnt:  e_state_d = CtrSnt;
                default: e_state_d = CtrSnt;
            endcase
        end
    end

    // Flush outranks any update; a taken miss allocates over whatever sits at the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                state_q[i]  <= CtrSnt;
            end
        end else if (flush_btb) begin
            valid_q <= '0;
        end else if (update_btb) begin
            if (e_hit) begin
                state_q[e_idx] <= e_state_d;
                if (ex_taken) begin
                    target_q[e_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target;
                state_q[e_idx]  <= CtrWt;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: drives on the falling edge, checks 1ns later.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        predictedTaken;
    logic [31:0] predicted_target;
    logic [31:0] next_fetch_pc;
    logic        update_btb;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush_btb;

    int n_cmp  = 0;
    int n_fail = 0;

    btb_predictor #(.INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc         (fetch_pc),
        .predictedTaken   (predictedTaken),
        .predicted_target (predicted_target),
        .next_fetch_pc    (next_fetch_pc),
        .update_btb       (update_btb),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .flush_btb        (flush_btb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Set fetch_pc and check all three lookup outputs against the expected prediction.
    task automatic look(input string tag, input logic [31:0] pc, input logic exp_pt,
                        input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check({tag, ".taken"}, {31'd0, predictedTaken}, {31'd0, exp_pt});
        check({tag, ".target"}, predicted_target, exp_pt ? exp_tgt : 32'd0);
        check({tag, ".next"}, next_fetch_pc, exp_pt ? exp_tgt : pc + 32'd4);
    endtask

    // One-cycle update pulse; returns on the falling edge after it was applied.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        @(negedge clk);
        update_btb = 1'b1;
        ex_pc      = pc;
        ex_taken   = taken;
        ex_target  = tgt;
        @(negedge clk);
        update_btb = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_pc   = 32'h100;
        update_btb = 1'b1;
        ex_pc      = 32'h100;
        ex_taken   = 1'b1;
        ex_target  = 32'h200;
        flush_btb  = 1'b0;

        // Updates during reset are ignored; outputs show a miss.
        repeat (2) @(negedge clk);
        look("in_reset", 32'h100, 1'b0, 32'h0);
        update_btb = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        look("cold", 32'h100, 1'b0, 32'h0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Not-taken miss does not allocate.
        upd(32'h300, 1'b0, 32'h900);
        look("nt_miss", 32'h300, 1'b0, 32'h0);

        // Allocate at WT, then saturate to ST.
        upd(32'h100, 1'b1, 32'h200);
        look("alloc", 32'h100, 1'b1, 32'h200);
        look("alloc_lsb", 32'h103, 1'b1, 32'h200);
        repeat (3) upd(32'h100, 1'b1, 32'h200);
        // ST -> WT; target kept on not-taken.
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("st_wt", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("wt_wnt", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("wnt_snt", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h240);
        look("snt_wnt", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h240);
        look("wnt_wt", 32'h100, 1'b1, 32'h240);

        // Aliasing: 0x140 shares index 0 with 0x100.
        upd(32'h140, 1'b1, 32'h500);
        look("alias_old", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 32'h500);
        upd(32'h104, 1'b1, 32'h800);
        look("other_idx", 32'h104, 1'b1, 32'h800);
        look("alias_kept", 32'h140, 1'b1, 32'h500);

        // Same-cycle lookup and update: old view now, new view next cycle.
        @(negedge clk);
        update_btb = 1'b1;
        ex_pc      = 32'h140;
        ex_taken   = 1'b0;
        ex_target  = 32'h0;
        look("same_cyc_old", 32'h140, 1'b1, 32'h500);
        @(negedge clk);
        update_btb = 1'b0;
        look("same_cyc_new", 32'h140, 1'b0, 32'h0);

        // Flush wins over a simultaneous taken update.
        @(negedge clk);
        flush_btb  = 1'b1;
        update_btb = 1'b1;
        ex_pc      = 32'h300;
        ex_taken   = 1'b1;
        ex_target  = 32'h900;
        @(negedge clk);
        flush_btb  = 1'b0;
        update_btb = 1'b0;
        look("flush_upd", 32'h300, 1'b0, 32'h0);
        look("flush_104", 32'h104, 1'b0, 32'h0);
        look("flush_140", 32'h140, 1'b0, 32'h0);
        upd(32'h300, 1'b1, 32'h900);
        look("post_flush", 32'h300, 1'b1, 32'h900);

        // Asynchronous reset between edges, with an update in flight.
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h104, 1'b1, 32'h800);
        look("pre_rst", 32'h100, 1'b1, 32'h200);
        @(negedge clk);
        update_btb = 1'b1;
        ex_pc      = 32'h108;
        ex_taken   = 1'b1;
        ex_target  = 32'hB00;
        #2;
        rst_n = 1'b0;
        look("async_rst", 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        ex_pc     = 32'h10C;
        ex_target = 32'hC00;
        rst_n     = 1'b1;
        @(negedge clk);
        update_btb = 1'b0;
        look("first_upd", 32'h10C, 1'b1, 32'hC00);
        look("rst_108", 32'h108, 1'b0, 32'h0);
        look("rst_100", 32'h100, 1'b0, 32'h0);
        look("rst_104", 32'h104, 1'b0, 32'h0);
        look("rst_300", 32'h300, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, meaning log2 of the entry count (16 entries), direct-mapped.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port fetch_pc, input, 32, PC of the instruction currently in fetch.
REQ-005 SHALL have port predictedTaken, output, 1, fetch-side taken prediction; carried down the pipe to the branch-resolve stage.
REQ-006 SHALL have port predicted_target, output, 32, target stored for fetch_pc; 0 when there is no hit.
REQ-007 SHALL have port next_fetch_pc, output, 32, predicted_target when predictedTaken is 1, otherwise fetch_pc+4.
REQ-008 SHALL have port update_btb, input, 1, the resolving instruction in execute is a branch, JAL or JALR.
REQ-009 SHALL have port ex_pc, input, 32, PC of the resolving instruction.
REQ-010 SHALL have port ex_taken, input, 1, actual outcome (jump, or branch condition true).
REQ-011 SHALL have port ex_target, input, 32, resolved jump_addr, with the LSB already cleared for JALR.
REQ-012 SHALL have port flush_btb, input, 1, synchronous invalidate of all entries.

Function
REQ-013 SHALL derive index = pc[INDEX_BITS+1:2] and tag = pc[31:INDEX_BITS+2] for both fetch_pc and ex_pc; pc[1:0] is ignored.
REQ-014 SHALL hold the following per entry: valid (1), tag, target (32) and state (2), with SNT=00, WNT=01, ST=10, WT=11.
REQ-015 SHALL compute the lookup combinationally: hit = valid && tag match; predictedTaken = hit && state[1].
REQ-016 SHALL, on a miss or when predictedTaken=0, output predicted_target=0 and next_fetch_pc=fetch_pc+4, with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000).
REQ-017 SHALL, on a hit with update_btb=1, update state as a saturating counter:
- taken: SNT->WNT, WNT->WT, WT->ST, ST->ST.
- not taken: ST->WT, WT->WNT, WNT->SNT, SNT->SNT.
REQ-018 SHALL, on a hit with update_btb=1 and ex_taken=1, overwrite target with ex_target.
REQ-019 SHALL, on a hit with update_btb=1 and ex_taken=0, leave target unchanged.
REQ-020 SHALL, on a miss with update_btb=1 and ex_taken=1, allocate the entry: valid=1, tag=ex tag, target=ex_target, state=WT. This replaces any valid entry that has a different tag.
REQ-021 SHALL, on a miss with update_btb=1 and ex_taken=0, make no change (no allocation).
REQ-022 SHALL make no state change when update_btb=0.
REQ-023 SHALL apply an update in the cycle after the edge at which it is sampled; a lookup and update of the same index in the same cycle returns the pre-update contents (no bypass).
REQ-024 SHALL apply at most one update per cycle; there is no handshake, and the update is accepted unconditionally.
REQ-025 SHALL give flush_btb priority over a simultaneous update: all valid bits clear and the update is dropped; targets, tags and states may be left stale.
REQ-026 SHALL produce lookup outputs that are purely combinational from fetch_pc and stored state, with zero latency.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, clear every valid bit and set every state to SNT.
REQ-028 SHALL, during reset, drive predictedTaken=0, predicted_target=0 and next_fetch_pc=fetch_pc+4.
REQ-029 SHALL ignore updates sampled while rst_n=0.
REQ-030 SHALL, when reset is asserted mid-update, leave no partially written entry visible after reset releases.
REQ-031 SHALL accept the first update at the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL cover cold lookup: after reset, fetch_pc=0x100 -> predictedTaken=0, predicted_target=0, next_fetch_pc=0x104.
REQ-033 SHALL cover allocate and predict:
- update ex_pc=0x100, ex_taken=1, ex_target=0x200 for one cycle.
- Next cycle, fetch_pc=0x100 -> predictedTaken=1, next_fetch_pc=0x200, state=WT.
REQ-034 SHALL cover counter saturation and decay:
- Three taken updates to 0x100 -> state ST.
- Then one not-taken -> WT, predictedTaken still 1.
- Second not-taken -> WNT, predictedTaken=0, next_fetch_pc=0x104.
REQ-035 SHALL cover aliasing: entry 0x100 allocated, then taken update ex_pc=0x140 (same index, different tag) -> lookup 0x100 misses and lookup 0x140 hits with the new target.
REQ-036 SHALL cover same-cycle lookup and update plus flush:
- Lookup and update of 0x100 in one cycle -> the old prediction is seen that cycle and the new one the next cycle.
- flush_btb=1 together with update_btb=1 -> all lookups miss afterwards.
REQ-037 SHALL cover asynchronous reset: rst_n driven low between clock edges after several allocations -> predictedTaken=0 immediately, and every entry misses after release.
